cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single result-broadcast bus into the reorder buffer between the ALU/reservation-station
//  path and the load/store buffer. Each source is buffered in its own small FIFO.
//  Round-robin arbitration drives one registered broadcast per cycle onto the bus.
//  The bus feeds the reorder buffer's result write and the operand wake-up logic.
//  The whole block is flushed on rollback.
// PARAMETERS
//  QDEPTH    2   entries per source queue (power of two, >=2)
//  POS_W     4   reorder-buffer index width (16 entries)
// PORTS
//  clk           in   1      clock; all state on posedge
//  rst           in   1      synchronous, active-high reset
//  rdy           in   1      global ready; low freezes all state
//  rollback      in   1      flush from reorder buffer; same effect as rst
//  alu_valid     in   1      ALU result offered this cycle
//  alu_rob_pos   in   POS_W  destination reorder-buffer slot
//  alu_val       in   32     result value
//  alu_jump      in   1      branch resolved taken
//  alu_pc        in   32     resolved next pc
//  alu_stall     out  1      ALU queue full; ALU must not assert alu_valid
//  lsb_valid     in   1      load/store result offered
//  lsb_rob_pos   in   POS_W  destination slot
//  lsb_val       in   32     loaded value
//  lsb_stall     out  1      LSB queue full
//  cdb_valid     out  1      broadcast valid
//  cdb_rob_pos   out  POS_W  broadcast slot
//  cdb_val       out  32     broadcast value
//  cdb_jump      out  1      taken flag; 0 for LSB entries
//  cdb_pc        out  32     resolved pc; 0 for LSB entries
//  cdb_src       out  1      0 = ALU, 1 = LSB
//  ovf_err       out  1      sticky: a valid arrived while its queue was full
// BEHAVIOUR
//  - Reset (rst or rollback at posedge):
//    - Both queues are emptied.
//    - cdb_valid, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc and cdb_src are all set to 0.
//    - last_grant is set to LSB, so the ALU wins the first tie.
//    - ovf_err is cleared by rst only; rollback does not clear it.
//  - rdy=0: every register holds its value. Inputs are ignored and nothing is enqueued.
//  - Stall signals:
//    - x_stall = (count_x == QDEPTH), combinational from registered count only.
//    - An x_valid arriving while x_stall=1 is dropped and sets ovf_err.
//  - Enqueue: at edge E, x_valid=1 with queue not full writes the entry at the tail.
//  - Arbitration (combinational on queue heads, registered at edge):
//    - Exactly one queue non-empty: grant it.
//    - Both non-empty: grant the source != last_grant; last_grant <= winner.
//    - Neither non-empty: cdb_valid <= 0; last_grant unchanged.
//    - Granted head is popped and copied into the cdb_* registers; cdb_valid <= 1.
//  - Latency: an entry enqueued at edge E appears on the bus earliest at edge E+1, i.e. valid in the
//    cycle after E+1. Throughput is 1 broadcast per cycle.
//  - Push and pop on the same queue at the same edge is legal at any fill level below full.
//    count is unchanged in that case.
//  - Queue pointers are log2(QDEPTH) bits and wrap naturally. count is log2(QDEPTH)+1 bits.
//  - Rollback at the same edge as a valid input or a pending grant: the flush wins; the input is
//    discarded and cdb_valid <= 0.
//  - Ordering: FIFO order is kept within each source. No ordering is guaranteed across sources.
//  - Liveness: while both queues stay non-empty, no source waits more than 1 grant.
// STRUCTURE
//  - Shared package/constants header:
//    - POS_W and the source IDs SRC_ALU=0 and SRC_LSB=1.
//    - The 65+POS_W-bit result entry layout {rob_pos, val, jump, pc}.
//  - Sub-module result_queue (parameter QDEPTH, WIDTH), instantiated twice.
//    - Ports: push, din, pop, dout, empty, full, flush.
//  - Top level holds last_grant, the grant logic, the cdb registers and ovf_err.
// TESTING
//  1 Reset, then ALU valid pos=3 val=0x11 for 1 cycle
//    -> cdb_valid=1, pos=3, val=0x11, src=0 exactly 2 edges later; then cdb_valid=0.
//  2 ALU pos=1 and LSB pos=2 in the same cycle, twice in a row
//    -> bus order ALU1, LSB2, ALU1', LSB2' on consecutive cycles (alternating).
//  3 ALU valid 3 consecutive cycles with QDEPTH=2 while LSB is saturated
//    -> alu_stall=1 once 2 entries are held; a 3rd push under stall sets ovf_err=1.
//  4 Both queues holding 2 entries, assert rollback
//    -> next cycle cdb_valid=0, both stalls 0, nothing broadcast afterwards.
//  5 rdy=0 for 3 cycles with entries queued and cdb_valid=1
//    -> all cdb_* outputs stable; sequence resumes unchanged when rdy=1.
//  6 LSB result pos=15 val=0xFFFFFFFF
//    -> cdb_jump=0, cdb_pc=0, src=1. Also check 5 pushes per queue: pointer wrap keeps FIFO order.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the result-entry layout carried by both source queues
// and the broadcast bus.
package cdb_arbiter_pkg;

   localparam int POS_W = 4;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSB = 1'b1;

   typedef struct packed {
      logic [POS_W-1:0] rob_pos;
      logic [31:0]      val;
      logic             jump;
      logic [31:0]      pc;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   function automatic entry_t make_entry(input logic [POS_W-1:0] rob_pos,
                                         input logic [31:0]      val,
                                         input logic             jump,
                                         input logic [31:0]      pc);
      entry_t e;
      e.rob_pos = rob_pos;
      e.val     = val;
      e.jump    = jump;
      e.pc      = pc;
      return e;
   endfunction

endpackage

// File: rtl/cdb_arbiter_queue.sv
// Small circular FIFO holding pending results for one bus source.
// Pointers wrap naturally; flush empties the queue in one cycle.
module result_queue #(
   parameter int QDEPTH = 2,
   parameter int WIDTH  = 69
) (
   input  logic             clk,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);

   logic [WIDTH-1:0] mem [QDEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[head];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[tail] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            tail <= tail + 1'b1;
         end
         if (do_pop) begin
            head <= head + 1'b1;
         end
         // simultaneous push and pop leaves the fill level unchanged
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the result-broadcast bus between the ALU and the
// load/store buffer, one registered broadcast per cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             alu_valid,
   input  logic [POS_W-1:0] alu_rob_pos,
   input  logic [31:0]      alu_val,
   input  logic             alu_jump,
   input  logic [31:0]      alu_pc,
   output logic             alu_stall,
   input  logic             lsb_valid,
   input  logic [POS_W-1:0] lsb_rob_pos,
   input  logic [31:0]      lsb_val,
   output logic             lsb_stall,
   output logic             cdb_valid,
   output logic [POS_W-1:0] cdb_rob_pos,
   output logic [31:0]      cdb_val,
   output logic             cdb_jump,
   output logic [31:0]      cdb_pc,
   output logic             cdb_src,
   output logic             ovf_err
);

   logic   flush;
   logic   alu_push, lsb_push;
   logic   alu_pop, lsb_pop;
   logic   alu_empty, lsb_empty;
   logic   alu_full, lsb_full;
   logic   alu_ne, lsb_ne;
   logic   any_req, tie;
   logic   grant;
   logic   last_grant;
   entry_t alu_in, lsb_in;
   entry_t alu_head, lsb_head;
   entry_t win_head;

   assign flush = rst | rollback;

   assign alu_in = make_entry(alu_rob_pos, alu_val, alu_jump, alu_pc);
   assign lsb_in = make_entry(lsb_rob_pos, lsb_val, 1'b0, 32'h0);

   assign alu_stall = alu_full;
   assign lsb_stall = lsb_full;

   assign alu_push = rdy & ~flush & alu_valid & ~alu_full;
   assign lsb_push = rdy & ~flush & lsb_valid & ~lsb_full;

   assign alu_ne = ~alu_empty;
   assign lsb_ne = ~lsb_empty;

   always_comb begin
      any_req = alu_ne | lsb_ne;
      tie     = alu_ne & lsb_ne;
      grant   = SRC_ALU;
      if (tie) begin
         grant = ~last_grant;
      end else if (lsb_ne) begin
         grant = SRC_LSB;
      end
      win_head = (grant == SRC_LSB) ? lsb_head : alu_head;
   end

   assign alu_pop = rdy & ~flush & alu_ne & (grant == SRC_ALU);
   assign lsb_pop = rdy & ~flush & lsb_ne & (grant == SRC_LSB);

   result_queue #(.QDEPTH(QDEPTH), .WIDTH(ENTRY_W)) u_alu_q (
      .clk   (clk),
      .flush (flush),
      .push  (alu_push),
      .din   (alu_in),
      .pop   (alu_pop),
      .dout  (alu_head),
      .empty (alu_empty),
      .full  (alu_full)
   );

   result_queue #(.QDEPTH(QDEPTH), .WIDTH(ENTRY_W)) u_lsb_q (
      .clk   (clk),
      .flush (flush),
      .push  (lsb_push),
      .din   (lsb_in),
      .pop   (lsb_pop),
      .dout  (lsb_head),
      .empty (lsb_empty),
      .full  (lsb_full)
   );

   // last_grant only moves on a genuine contention so a lone source never
   // steals the next tie from the other one
   always_ff @(posedge clk) begin
      if (flush) begin
         cdb_valid   <= 1'b0;
         cdb_rob_pos <= '0;
         cdb_val     <= '0;
         cdb_jump    <= 1'b0;
         cdb_pc      <= '0;
         cdb_src     <= SRC_ALU;
         last_grant  <= SRC_LSB;
      end else if (rdy) begin
         cdb_valid <= any_req;
         if (any_req) begin
            cdb_rob_pos <= win_head.rob_pos;
            cdb_val     <= win_head.val;
            cdb_jump    <= win_head.jump;
            cdb_pc      <= win_head.pc;
            cdb_src     <= grant;
         end
         if (tie) begin
            last_grant <= grant;
         end
      end
   end

   // rollback discards the input but keeps the overflow history
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_err <= 1'b0;
      end else if (rdy && !rollback) begin
         if ((alu_valid && alu_full) || (lsb_valid && lsb_full)) begin
            ovf_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, alternation, stall/overflow,
// rollback, rdy freeze, LSB field zeroing and pointer wrap.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic             clk;
   logic             rst;
   logic             rdy;
   logic             rollback;
   logic             alu_valid;
   logic [POS_W-1:0] alu_rob_pos;
   logic [31:0]      alu_val;
   logic             alu_jump;
   logic [31:0]      alu_pc;
   logic             alu_stall;
   logic             lsb_valid;
   logic [POS_W-1:0] lsb_rob_pos;
   logic [31:0]      lsb_val;
   logic             lsb_stall;
   logic             cdb_valid;
   logic [POS_W-1:0] cdb_rob_pos;
   logic [31:0]      cdb_val;
   logic             cdb_jump;
   logic [31:0]      cdb_pc;
   logic             cdb_src;
   logic             ovf_err;

   int errors = 0;
   int checks = 0;

   cdb_arbiter #(.QDEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .rollback    (rollback),
      .alu_valid   (alu_valid),
      .alu_rob_pos (alu_rob_pos),
      .alu_val     (alu_val),
      .alu_jump    (alu_jump),
      .alu_pc      (alu_pc),
      .alu_stall   (alu_stall),
      .lsb_valid   (lsb_valid),
      .lsb_rob_pos (lsb_rob_pos),
      .lsb_val     (lsb_val),
      .lsb_stall   (lsb_stall),
      .cdb_valid   (cdb_valid),
      .cdb_rob_pos (cdb_rob_pos),
      .cdb_val     (cdb_val),
      .cdb_jump    (cdb_jump),
      .cdb_pc      (cdb_pc),
      .cdb_src     (cdb_src),
      .ovf_err     (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [POS_W-1:0] pos, input logic [31:0] val,
                          input logic jump, input logic [31:0] pc);
      alu_valid   = v;
      alu_rob_pos = pos;
      alu_val     = val;
      alu_jump    = jump;
      alu_pc      = pc;
   endtask

   task automatic set_lsb(input logic v, input logic [POS_W-1:0] pos, input logic [31:0] val);
      lsb_valid   = v;
      lsb_rob_pos = pos;
      lsb_val     = val;
   endtask

   task automatic idle();
      set_alu(1'b0, '0, 32'h0, 1'b0, 32'h0);
      set_lsb(1'b0, '0, 32'h0);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic bus(input string tag, input logic [31:0] pos, input logic [31:0] val,
                      input logic [31:0] src);
      check({tag, "_valid"}, 32'(cdb_valid), 32'd1);
      check({tag, "_pos"},   32'(cdb_rob_pos), pos);
      check({tag, "_val"},   cdb_val, val);
      check({tag, "_src"},   32'(cdb_src), src);
   endtask

   initial begin
      rst      = 1'b1;
      rdy      = 1'b1;
      rollback = 1'b0;
      idle();
      step();
      step();
      rst = 1'b0;

      // reset state
      check("rst_valid", 32'(cdb_valid), 32'd0);
      check("rst_pos",   32'(cdb_rob_pos), 32'd0);
      check("rst_val",   cdb_val, 32'd0);
      check("rst_src",   32'(cdb_src), 32'd0);
      check("rst_astall", 32'(alu_stall), 32'd0);
      check("rst_lstall", 32'(lsb_stall), 32'd0);
      check("rst_ovf",   32'(ovf_err), 32'd0);

      // 1: single ALU result, two-edge latency
      set_alu(1'b1, 4'd3, 32'h11, 1'b0, 32'h0);
      step();
      idle();
      check("t1_lat", 32'(cdb_valid), 32'd0);
      step();
      bus("t1_bc", 32'd3, 32'h11, 32'd0);
      step();
      check("t1_done", 32'(cdb_valid), 32'd0);

      // 2: simultaneous ALU/LSB twice -> alternating order
      do_reset();
      set_alu(1'b1, 4'd1, 32'hA1, 1'b1, 32'h100);
      set_lsb(1'b1, 4'd2, 32'hB1);
      step();
      set_alu(1'b1, 4'd1, 32'hA2, 1'b0, 32'h200);
      set_lsb(1'b1, 4'd2, 32'hB2);
      step();
      idle();
      bus("t2_e1", 32'd1, 32'hA1, 32'd0);
      check("t2_e1_jump", 32'(cdb_jump), 32'd1);
      check("t2_e1_pc",   cdb_pc, 32'h100);
      step();
      bus("t2_e2", 32'd2, 32'hB1, 32'd1);
      step();
      bus("t2_e3", 32'd1, 32'hA2, 32'd0);
      step();
      bus("t2_e4", 32'd2, 32'hB2, 32'd1);
      step();
      check("t2_done", 32'(cdb_valid), 32'd0);

      // 3: ALU queue fills, push under stall sets ovf_err
      do_reset();
      set_alu(1'b1, 4'd8, 32'h30, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd9, 32'h40);
      step();
      set_alu(1'b1, 4'd8, 32'h31, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd9, 32'h41);
      step();
      check("t3_e1_val", cdb_val, 32'h30);
      check("t3_e1_lstall", 32'(lsb_stall), 32'd1);
      check("t3_e1_astall", 32'(alu_stall), 32'd0);
      set_alu(1'b1, 4'd8, 32'h32, 1'b0, 32'h0);
      set_lsb(1'b0, 4'd9, 32'h0);
      step();
      check("t3_e2_val", cdb_val, 32'h40);
      check("t3_e2_astall", 32'(alu_stall), 32'd1);
      check("t3_e2_lstall", 32'(lsb_stall), 32'd0);
      check("t3_e2_ovf", 32'(ovf_err), 32'd0);
      set_alu(1'b1, 4'd8, 32'h33, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd9, 32'h42);
      step();
      idle();
      check("t3_e3_val", cdb_val, 32'h31);
      check("t3_e3_ovf", 32'(ovf_err), 32'd1);
      check("t3_e3_astall", 32'(alu_stall), 32'd0);
      check("t3_e3_lstall", 32'(lsb_stall), 32'd1);
      step();
      bus("t3_e4", 32'd9, 32'h41, 32'd1);
      step();
      bus("t3_e5", 32'd8, 32'h32, 32'd0);
      step();
      bus("t3_e6", 32'd9, 32'h42, 32'd1);
      step();
      check("t3_done", 32'(cdb_valid), 32'd0);

      // 4: rollback with entries queued and a valid at the same edge
      set_alu(1'b1, 4'd4, 32'h50, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd5, 32'h60);
      step();
      set_alu(1'b1, 4'd4, 32'h51, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd5, 32'h61);
      step();
      bus("t4_e1", 32'd5, 32'h60, 32'd1);
      check("t4_e1_astall", 32'(alu_stall), 32'd1);
      set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd5, 32'h62);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      idle();
      check("t4_rb_valid", 32'(cdb_valid), 32'd0);
      check("t4_rb_pos",   32'(cdb_rob_pos), 32'd0);
      check("t4_rb_val",   cdb_val, 32'd0);
      check("t4_rb_astall", 32'(alu_stall), 32'd0);
      check("t4_rb_lstall", 32'(lsb_stall), 32'd0);
      check("t4_rb_ovf",   32'(ovf_err), 32'd1);
      for (int i = 0; i < 2; i++) begin
         step();
         check("t4_quiet", 32'(cdb_valid), 32'd0);
      end

      // 5: rdy low freezes state and ignores inputs
      set_alu(1'b1, 4'd6, 32'h66, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd7, 32'h77);
      step();
      set_alu(1'b1, 4'd8, 32'h88, 1'b0, 32'h0);
      set_lsb(1'b0, 4'd0, 32'h0);
      step();
      bus("t5_pre", 32'd6, 32'h66, 32'd0);
      rdy = 1'b0;
      set_alu(1'b1, 4'd14, 32'hEE, 1'b1, 32'hEE);
      set_lsb(1'b1, 4'd14, 32'hEF);
      for (int i = 0; i < 3; i++) begin
         step();
         bus("t5_hold", 32'd6, 32'h66, 32'd0);
         check("t5_hold_astall", 32'(alu_stall), 32'd0);
      end
      rdy = 1'b1;
      idle();
      step();
      bus("t5_r1", 32'd7, 32'h77, 32'd1);
      step();
      bus("t5_r2", 32'd8, 32'h88, 32'd0);
      step();
      check("t5_done", 32'(cdb_valid), 32'd0);

      // 6: LSB entry zeroes jump/pc, max slot and value
      do_reset();
      set_alu(1'b1, 4'd9, 32'h99, 1'b1, 32'h1234);
      step();
      set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      set_lsb(1'b1, 4'd15, 32'hFFFF_FFFF);
      step();
      idle();
      bus("t6_alu", 32'd9, 32'h99, 32'd0);
      check("t6_alu_jump", 32'(cdb_jump), 32'd1);
      check("t6_alu_pc",   cdb_pc, 32'h1234);
      step();
      bus("t6_lsb", 32'd15, 32'hFFFF_FFFF, 32'd1);
      check("t6_lsb_jump", 32'(cdb_jump), 32'd0);
      check("t6_lsb_pc",   cdb_pc, 32'h0);
      step();
      check("t6_done", 32'(cdb_valid), 32'd0);

      // pointer wrap: five results through each queue in order
      for (int i = 0; i < 6; i++) begin
         set_alu((i < 5) ? 1'b1 : 1'b0, 4'(i), 32'(32'h100 + i), 1'b0, 32'h0);
         step();
         if (i >= 1) bus("wrap_alu", 32'(i - 1), 32'(32'h100 + i - 1), 32'd0);
      end
      idle();
      for (int i = 0; i < 6; i++) begin
         set_lsb((i < 5) ? 1'b1 : 1'b0, 4'(i + 8), 32'(32'h200 + i));
         step();
         if (i >= 1) bus("wrap_lsb", 32'(i + 7), 32'(32'h200 + i - 1), 32'd1);
      end
      idle();
      step();
      check("wrap_done", 32'(cdb_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
